// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        LdIdle,
        LdLenLo,
        LdLenHi,
        LdData,
        LdDone
    } ld_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, bit timer and receive FSM.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] FullBit = CntW'(CLKS_PER_BIT);

    rx_state_e       state;
    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    logic [CntW-1:0] cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    assign byte_data = shreg;

    // cnt holds cycles elapsed since the last sample point; the detect cycle counts as 1
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RxIdle;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RxIdle: begin
                    if (rx_prev && !rx_sync) begin
                        state <= RxStart;
                        cnt   <= CntW'(1);
                    end
                end
                RxStart: begin
                    if (cnt == HalfBit) begin
                        cnt     <= CntW'(1);
                        bit_idx <= '0;
                        state   <= rx_sync ? RxIdle : RxData;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (cnt == FullBit) begin
                        cnt     <= CntW'(1);
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RxStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (cnt == FullBit) begin
                        if (rx_sync) byte_valid <= 1'b1;
                        else         frame_err  <= 1'b1;
                        state <= RxIdle;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// UART program loader: receives a length-prefixed byte stream and writes it
// word by word into instruction memory while holding the core in reset.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DEPTH_WORDS  = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        rx,
    input  logic        start,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned LaneW = $clog2(WORD_BYTES);
    localparam logic [LaneW-1:0] LastLane = LaneW'(WORD_BYTES - 1);

    logic        byte_valid;
    logic        frame_err;
    logic [7:0]  byte_data;

    ld_state_e        state;
    logic [15:0]      len;
    logic [15:0]      word_cnt;
    logic [LaneW-1:0] lane;
    logic [23:0]      word_sh;
    logic             core_rst_q;
    logic [15:0]      len_full;
    logic             len_bad;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK       (CLK),
        .RST       (RST),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign len_full = {byte_data, len[7:0]};
    assign len_bad  = 32'(len_full) > DEPTH_WORDS;
    // The core also sees the system reset directly, not only the registered hold.
    assign core_rst = core_rst_q | RST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= LdIdle;
            len        <= '0;
            word_cnt   <= '0;
            lane       <= '0;
            word_sh    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            core_rst_q <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (frame_err && (state inside {LdLenLo, LdLenHi, LdData})) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                lane  <= '0;
                state <= LdIdle;
            end else begin
                case (state)
                    LdIdle: begin
                        if (start) begin
                            core_rst_q <= 1'b1;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            err        <= 1'b0;
                            word_cnt   <= '0;
                            wr_addr    <= '0;
                            lane       <= '0;
                            state      <= LdLenLo;
                        end
                    end
                    LdLenLo: begin
                        if (byte_valid) begin
                            len[7:0] <= byte_data;
                            state    <= LdLenHi;
                        end
                    end
                    LdLenHi: begin
                        if (byte_valid) begin
                            len[15:8] <= byte_data;
                            if (len_full == 16'd0) begin
                                done       <= 1'b1;
                                core_rst_q <= 1'b0;
                                busy       <= 1'b0;
                                state      <= LdIdle;
                            end else if (len_bad) begin
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                state <= LdIdle;
                            end else begin
                                state <= LdData;
                            end
                        end
                    end
                    LdData: begin
                        if (byte_valid) begin
                            lane <= lane + 1'b1;
                            if (lane == LastLane) begin
                                wr_en    <= 1'b1;
                                wr_data  <= {byte_data, word_sh};
                                wr_addr  <= {14'b0, word_cnt, 2'b00};
                                word_cnt <= word_cnt + 16'd1;
                                if (word_cnt + 16'd1 == len) state <= LdDone;
                            end else begin
                                word_sh <= {byte_data, word_sh[23:8]};
                            end
                        end
                    end
                    LdDone: begin
                        done       <= 1'b1;
                        core_rst_q <= 1'b0;
                        busy       <= 1'b0;
                        state      <= LdIdle;
                    end
                    default: state <= LdIdle;
                endcase
            end
        end
    end

endmodule
